carry_lookahead_adder_32: RTL and testbench

- 32-bit unsigned adder built from a two-level carry-lookahead network.
- Produces a 33-bit sum; bit 32 is the carry-out.
- Used as the exact reference adder in the adder library. Approximate adders are compared against it.
- Registered output: the adder tree is combinational and the result is captured in one output register on a single clock.

---
 rtl/cla_adder_pkg.sv | 43 ++++
 rtl/cla_block4.sv | 26 ++
 rtl/carry_lookahead_adder_32.sv | 74 +++++++
 tb/tb_carry_lookahead_adder_32.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cla_adder_pkg.sv
// Shared types, sizes and the 4-wide lookahead equations for the 32-bit CLA adder.
// The same cla_lookahead4 function serves both the bit-level blocks and the group level.
package cla_adder_pkg;

    localparam int CLA_WIDTH  = 32;
    localparam int CLA_BLOCK  = 4;
    localparam int CLA_GROUPS = CLA_WIDTH / CLA_BLOCK;

    typedef logic [CLA_WIDTH-1:0] operand_t;
    typedef logic [CLA_WIDTH:0]   result_t;

    // carry[i] is the carry into position i of a 4-wide slice; position 0 is the slice carry-in.
    typedef struct packed {
        logic [3:1] carry;
        logic       grp_g;
        logic       grp_p;
    } lookahead_t;

    // Flat sum-of-products lookahead: every carry depends only on g, p and cin, never on another carry.
    function automatic lookahead_t cla_lookahead4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        lookahead_t la;
        la.carry[1] = g[0]
                    | (p[0] & cin);
        la.carry[2] = g[1]
                    | (p[1] & g[0])
                    | (p[1] & p[0] & cin);
        la.carry[3] = g[2]
                    | (p[2] & g[1])
                    | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & cin);
        la.grp_g    = g[3]
                    | (p[3] & g[2])
                    | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
        la.grp_p    = &p;
        return la;
    endfunction

endpackage

// File: rtl/cla_block4.sv
// First-level 4-bit carry-lookahead block: local sum plus group generate/propagate.
// Purely combinational; the group carry-in comes from the level-2 lookahead in the top.
module cla_block4
    import cla_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_g,
    output logic       grp_p
);

    logic [3:0] g;
    logic [3:0] p;
    lookahead_t la;

    assign g  = a & b;
    assign p  = a ^ b;
    assign la = cla_lookahead4(g, p, cin);

    assign sum   = p ^ {la.carry, cin};
    assign grp_g = la.grp_g;
    assign grp_p = la.grp_p;

endmodule

// File: rtl/carry_lookahead_adder_32.sv
// Exact 32-bit two-level carry-lookahead adder with a registered 33-bit result.
// Define CLA_ADDER32_IN_REG_EN to register the operands as well (latency 2 instead of 1).
module carry_lookahead_adder_32
    import cla_adder_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLOCK = CLA_BLOCK
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    output logic [WIDTH:0]   result_o
);

    // Level 1 is BLOCK-wide groups; level 2 gathers four groups into a super-group.
    localparam int GROUPS = WIDTH / BLOCK;
    localparam int SUPERS = GROUPS / 4;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  sum;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS-1:0] grp_c;
    logic [SUPERS:0]   sup_c;

`ifdef CLA_ADDER32_IN_REG_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a <= '0;
            op_b <= '0;
        end else begin
            op_a <= add1_i;
            op_b <= add2_i;
        end
    end
`else
    assign op_a = add1_i;
    assign op_b = add2_i;
`endif

    for (genvar k = 0; k < GROUPS; k++) begin : g_blk
        cla_block4 u_blk (
            .a     (op_a[k*BLOCK +: 4]),
            .b     (op_b[k*BLOCK +: 4]),
            .cin   (grp_c[k]),
            .sum   (sum[k*BLOCK +: 4]),
            .grp_g (grp_g[k]),
            .grp_p (grp_p[k])
        );
    end

    // The adder has no carry-in port; bit 0 always starts from zero.
    assign sup_c[0] = 1'b0;

    for (genvar j = 0; j < SUPERS; j++) begin : g_sup
        lookahead_t sla;

        assign sla = cla_lookahead4(grp_g[j*4 +: 4], grp_p[j*4 +: 4], sup_c[j]);
        assign grp_c[j*4 +: 4] = {sla.carry, sup_c[j]};
        assign sup_c[j+1]      = sla.grp_g | (sla.grp_p & sup_c[j]);
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o <= '0;
        end else begin
            result_o <= {sup_c[SUPERS], sum};
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder_32.sv
// Directed and streaming self-check of carry_lookahead_adder_32 (latency 1, or 2 with CLA_ADDER32_IN_REG_EN).
module tb_carry_lookahead_adder_32;
    import cla_adder_pkg::*;

`ifdef CLA_ADDER32_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC  = 9;
    localparam int NRAND = 10000;

    typedef struct {
        operand_t a;
        operand_t b;
        result_t  exp;
    } vec_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b1;
    operand_t add1 = '0;
    operand_t add2 = '0;
    result_t  result;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs [NVEC];
    operand_t ra [NRAND];
    operand_t rb [NRAND];

    carry_lookahead_adder_32 dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .add1_i   (add1),
        .add2_i   (add2),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input result_t act, input result_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    endtask

    task automatic drive(input operand_t a, input operand_t b);
        @(negedge clk);
        add1 = a;
        add2 = b;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
        vecs[1] = '{32'hABCD_1234, 32'h0000_0000, 33'h0_ABCD_1234};
        vecs[2] = '{32'h0000_0000, 32'h1234_5678, 33'h0_1234_5678};
        vecs[3] = '{32'h8051_9860, 32'h8086_BA3E, 33'h1_00D8_529E};
        vecs[4] = '{32'hDEAD_BEEF, 32'h2020_2012, 33'h0_FECD_DF01};
        vecs[5] = '{32'h5555_5555, 32'hAAAA_AAAA, 33'h0_FFFF_FFFF};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
        vecs[7] = '{32'hDEAF_BEEF, 32'h0000_0001, 33'h0_DEAF_BEF0};
        vecs[8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};

        // Reset held while clocking with live operands.
        add1 = 32'h29AF_2430;
        add2 = 32'h7A1B_9ABC;
        #1 rst_n = 1'b0;
        #1 check("reset_async", result, '0);
        for (int i = 0; i < 3; i++) begin
            wait_edges(1);
            check("reset_held", result, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(LAT);
        check("reset_release", result, 33'h0_A3CA_BEEC);

        // Directed table, one vector at a time.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].a, vecs[i].b);
            wait_edges(LAT);
            check($sformatf("vec[%0d]", i), result, vecs[i].exp);
        end

        // Back-to-back streaming: new operands every cycle, no bubbles.
        for (int cyc = 0; cyc < NVEC + LAT - 1; cyc++) begin
            if (cyc < NVEC) drive(vecs[cyc].a, vecs[cyc].b);
            else @(negedge clk);
            wait_edges(1);
            if (cyc >= LAT - 1)
                check($sformatf("stream[%0d]", cyc - LAT + 1), result, vecs[cyc - LAT + 1].exp);
        end

        // Mid-stream reset asserted between edges must clear the output at once.
        drive(32'h8051_9860, 32'h8086_BA3E);
        wait_edges(LAT);
        check("pre_midreset", result, 33'h1_00D8_529E);
        #2 rst_n = 1'b0;
        #1 check("midreset_async", result, '0);
        drive(32'hDEAD_BEEF, 32'h2020_2012);
        wait_edges(1);
        check("midreset_held", result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(LAT);
        check("midreset_release", result, 33'h0_FECD_DF01);

        // Random streaming against the behavioural a+b model.
        for (int i = 0; i < NRAND; i++) begin
            ra[i] = $urandom;
            rb[i] = $urandom;
        end
        for (int cyc = 0; cyc < NRAND + LAT - 1; cyc++) begin
            if (cyc < NRAND) drive(ra[cyc], rb[cyc]);
            else @(negedge clk);
            wait_edges(1);
            if (cyc >= LAT - 1)
                check($sformatf("rand[%0d]", cyc - LAT + 1), result,
                      {1'b0, ra[cyc - LAT + 1]} + {1'b0, rb[cyc - LAT + 1]});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
